// File: rtl/hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: redirect, imem wait, load-use and MDU hazards.
// Optional HAZARD_PERF_CNT_EN adds saturating stall-cycle and redirect counters.
module hazard_ctrl #(
  parameter int unsigned MDU_LAT = 4,
  parameter int unsigned CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_mdu_rd,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rt_dst,
  input  logic       ex_mdu_start,
  input  logic       ex_redirect,
  input  logic       imem_ready,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       mdu_busy,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_events,
`endif
  output logic [1:0] hz_state
);

  typedef enum logic [1:0] {
    HZ_RUN       = 2'd0,
    HZ_LOAD_USE  = 2'd1,
    HZ_MDU_WAIT  = 2'd2,
    HZ_IMEM_WAIT = 2'd3
  } hz_e;

  hz_e              state_q, state_d;
  logic [CNT_W-1:0] mdu_cnt;
  logic             lu_haz, mdu_haz, id_haz;

  assign lu_haz = ex_mem_read && (ex_rt_dst != 5'd0) &&
                  ((id_uses_rs && (id_rs == ex_rt_dst)) ||
                   (id_uses_rt && (id_rt == ex_rt_dst)));
  assign mdu_busy = (mdu_cnt != '0);
  assign mdu_haz  = id_is_mdu_rd && (mdu_busy || ex_mdu_start);
  assign id_haz   = lu_haz || mdu_haz;
  assign hz_state = state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HZ_RUN;
    else        state_q <= state_d;
  end

  // Fixed-priority resolution; controls are held low while reset is asserted.
  always_comb begin
    state_d     = HZ_RUN;
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (rst_n) begin
      if (ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        state_d     = HZ_RUN;
      end else if (id_haz) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
        state_d     = lu_haz ? HZ_LOAD_USE : HZ_MDU_WAIT;
      end else if (!imem_ready) begin
        pc_stall    = 1'b1;
        if_id_flush = 1'b1;
        state_d     = HZ_IMEM_WAIT;
      end
    end
  end

  // MDU occupancy: a new issue restarts the count; redirects leave it alone (op is older).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            mdu_cnt <= '0;
    else if (ex_mdu_start) mdu_cnt <= CNT_W'(MDU_LAT - 1);
    else if (mdu_busy)     mdu_cnt <= mdu_cnt - CNT_W'(1);
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (pc_stall && (stall_cycles != 32'hFFFF_FFFF)) stall_cycles <= stall_cycles + 32'd1;
      if (ex_redirect && (flush_events != 32'hFFFF_FFFF)) flush_events <= flush_events + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl (MDU_LAT = 4).
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_rt_dst;
  logic       id_uses_rs, id_uses_rt, id_is_mdu_rd;
  logic       ex_mem_read, ex_mdu_start, ex_redirect, imem_ready;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_flush, mdu_busy;
  logic [1:0] hz_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_mdu_rd(id_is_mdu_rd),
    .ex_mem_read(ex_mem_read), .ex_rt_dst(ex_rt_dst),
    .ex_mdu_start(ex_mdu_start), .ex_redirect(ex_redirect),
    .imem_ready(imem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mdu_busy(mdu_busy),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles(stall_cycles), .flush_events(flush_events),
`endif
    .hz_state(hz_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    id_rs = 5'd0; id_rt = 5'd0; ex_rt_dst = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_is_mdu_rd = 1'b0;
    ex_mem_read = 1'b0; ex_mdu_start = 1'b0; ex_redirect = 1'b0;
    imem_ready = 1'b1;
  endtask

  // Advance past the next rising edge; inputs are driven and outputs sampled mid-cycle.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_lu();
    ex_mem_read = 1'b1; ex_rt_dst = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1;
  endtask

  task automatic chk_ctl(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, pc_stall, if_id_stall, if_id_flush, id_ex_flush}, {28'd0, exp});
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    imem_ready = 1'b0;
    set_lu();
    #3;
    chk_ctl("reset_ctl", 4'b0000);
    check("reset_busy", 32'(mdu_busy), 32'd0);
    check("reset_state", 32'(hz_state), 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // load-use on rs: one stall cycle, then release once the load moves on
    set_lu();
    #1 chk_ctl("lu_rs_ctl", 4'b1101);
    tick();
    check("lu_state", 32'(hz_state), 32'd1);
    idle();
    #1 chk_ctl("lu_release", 4'b0000);
    tick();
    check("lu_state_run", 32'(hz_state), 32'd0);

    // r0 destination never hazards
    ex_mem_read = 1'b1; ex_rt_dst = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    #1 chk_ctl("lu_r0", 4'b0000);
    // rt match only counts when rt is read
    idle();
    ex_mem_read = 1'b1; ex_rt_dst = 5'd9; id_rt = 5'd9; id_uses_rt = 1'b1;
    #1 chk_ctl("lu_rt", 4'b1101);
    id_uses_rt = 1'b0;
    #1 chk_ctl("lu_rt_unused", 4'b0000);
    idle();
    tick();

    // mfhi directly after mult issue: 4 stall cycles, busy 3 cycles
    ex_mdu_start = 1'b1; id_is_mdu_rd = 1'b1;
    #1 chk_ctl("mdu_c0_ctl", 4'b1101);
    check("mdu_c0_busy", 32'(mdu_busy), 32'd0);
    tick();
    ex_mdu_start = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      #1;
      chk_ctl($sformatf("mdu_c%0d_ctl", i), 4'b1101);
      check($sformatf("mdu_c%0d_busy", i), 32'(mdu_busy), 32'd1);
      check($sformatf("mdu_c%0d_state", i), 32'(hz_state), 32'd2);
      tick();
    end
    #1 chk_ctl("mdu_release", 4'b0000);
    check("mdu_release_busy", 32'(mdu_busy), 32'd0);
    tick();
    check("mdu_state_run", 32'(hz_state), 32'd0);
    idle();

    // second issue restarts the counter
    ex_mdu_start = 1'b1;
    tick();
    tick();
    ex_mdu_start = 1'b0;
    tick();
    tick();
    #1 check("mdu_restart_busy", 32'(mdu_busy), 32'd1);
    tick();
    check("mdu_restart_done", 32'(mdu_busy), 32'd0);

    // redirect does not clear the counter
    ex_mdu_start = 1'b1;
    tick();
    ex_mdu_start = 1'b0; ex_redirect = 1'b1;
    tick();
    ex_redirect = 1'b0;
    #1 check("mdu_redirect_busy", 32'(mdu_busy), 32'd1);
    tick(); tick();
    check("mdu_redirect_drain", 32'(mdu_busy), 32'd0);

    // imem wait for 3 cycles
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1 chk_ctl($sformatf("imem_c%0d_ctl", i), 4'b1010);
      tick();
      check($sformatf("imem_c%0d_state", i), 32'(hz_state), 32'd3);
    end
    imem_ready = 1'b1;
    #1 chk_ctl("imem_resume", 4'b0000);
    tick();
    check("imem_state_run", 32'(hz_state), 32'd0);

    // redirect beats imem wait and load-use
    ex_redirect = 1'b1; imem_ready = 1'b0; set_lu();
    #1 chk_ctl("redir_ctl", 4'b0011);
    tick();
    check("redir_state", 32'(hz_state), 32'd0);

    // ID hazard beats imem wait
    ex_redirect = 1'b0;
    #1 chk_ctl("lu_imem_ctl", 4'b1101);
    tick();
    check("lu_imem_state", 32'(hz_state), 32'd1);
    idle();
    tick();

    // async reset mid MDU stall
    ex_mdu_start = 1'b1; id_is_mdu_rd = 1'b1;
    tick();
    ex_mdu_start = 1'b0;
    tick();
    #1 check("rst_pre_busy", 32'(mdu_busy), 32'd1);
    check("rst_pre_state", 32'(hz_state), 32'd2);
    rst_n = 1'b0;
    #1 check("rst_mid_busy", 32'(mdu_busy), 32'd0);
    check("rst_mid_state", 32'(hz_state), 32'd0);
    chk_ctl("rst_mid_ctl", 4'b0000);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("rst_after_busy", 32'(mdu_busy), 32'd0);
    check("rst_after_state", 32'(hz_state), 32'd0);

`ifdef HAZARD_PERF_CNT_EN
    check("perf_stall_reset", stall_cycles, 32'd0);
    check("perf_flush_reset", flush_events, 32'd0);
    imem_ready = 1'b0;
    repeat (5) tick();
    imem_ready = 1'b1;
    ex_redirect = 1'b1;
    repeat (2) tick();
    ex_redirect = 1'b0;
    check("perf_stall_cnt", stall_cycles, 32'd5);
    check("perf_flush_cnt", flush_events, 32'd2);
    force dut.stall_cycles = 32'hFFFF_FFFF;
    #1 release dut.stall_cycles;
    imem_ready = 1'b0;
    tick();
    imem_ready = 1'b1;
    check("perf_stall_sat", stall_cycles, 32'hFFFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
